// File: rtl/reset_sequencer.sv
// Chip reset controller: qualifies PLL lock, releases domain resets one by one
// with a fixed stagger, and re-enters reset on lock loss or software request.
module reset_sequencer #(
  parameter int NUM_OUT        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int SWRST_CYCLES   = 8
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic               PLL_Locked,
  input  logic               SwResetReq,
  output logic [NUM_OUT-1:0] Domain_Reset,
  output logic               Seq_Done,
  output logic [1:0]         Seq_State,
  output logic [1:0]         Reset_Cause
);

  localparam int M_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int M_ALL = (M_HS > SWRST_CYCLES) ? M_HS : SWRST_CYCLES;
  localparam int CW = $clog2(M_ALL + 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] SWRST_LAST = CW'(SWRST_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SWRST   = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [NUM_OUT-1:0]   r_dr, w_dr_nxt, w_shift;
  logic                 r_done, w_done_nxt;
  logic [1:0]           r_cause, w_cause_nxt;
  logic                 w_lock;

  assign w_lock = r_sync[SYNC_STAGES-1];

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_sync  <= '0;
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_dr    <= '0;
      r_done  <= 1'b0;
      r_cause <= CAUSE_POR;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], PLL_Locked};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dr    <= w_dr_nxt;
      r_done  <= w_done_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dr_nxt    = r_dr;
    w_done_nxt  = r_done;
    w_cause_nxt = r_cause;
    // Next release pattern: one more low-order bit deasserted.
    w_shift     = r_dr << 1;
    w_shift[0]  = 1'b1;

    case (r_state)
      ST_HOLD: begin
        if (!w_lock) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_dr_nxt  = w_shift;
          w_cnt_nxt = '0;
          if (&w_shift) begin
            w_state_nxt = ST_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_RELEASE: begin
        if (!w_lock) begin
          w_dr_nxt    = '0;
          w_done_nxt  = 1'b0;
          w_cause_nxt = CAUSE_LOCK;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end else if (r_cnt == STAG_LAST) begin
          w_dr_nxt  = w_shift;
          w_cnt_nxt = '0;
          if (&w_shift) begin
            w_state_nxt = ST_RUN;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_RUN: begin
        // Lock loss outranks a simultaneous software request.
        if (!w_lock) begin
          w_dr_nxt    = '0;
          w_done_nxt  = 1'b0;
          w_cause_nxt = CAUSE_LOCK;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end else if (SwResetReq) begin
          w_dr_nxt    = '0;
          w_done_nxt  = 1'b0;
          w_cause_nxt = CAUSE_SW;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SWRST;
        end
      end

      ST_SWRST: begin
        if (r_cnt == SWRST_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
        w_dr_nxt    = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  assign Domain_Reset = r_dr;
  assign Seq_Done     = r_done;
  assign Seq_State    = r_state;
  assign Reset_Cause  = r_cause;

endmodule
